// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Two-requester round-robin arbiter and sequencer in front of the X/Y
//   addressed data memory (datamem). Requester A is the CPU load/store unit.
//   Requester B is the DMA/debug port. Each transaction takes
//   IDLE (grant) -> ISSUE (memory access) -> CAPTURE (registered Data_out),
//   so peak throughput is one transaction every 3 cycles.
//
// Ports
//   Clock, Resetn                     rising-edge clock, async active-low reset
//   a_valid/a_ready/a_we/a_addr/a_wdata    requester A request channel
//   a_rsp_valid/a_rsp_rdata                requester A one-cycle response
//   b_*                                    same as a_*, for requester B
//   mem_WriteEnable/X_addr/Y_addr/Data_in  registered drive into datamem
//   mem_Data_out                           registered read data from datamem
//   busy                                   high whenever not IDLE
module datamem_arbiter #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic                   a_we,
    input  logic [ADDR_BITS-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]  a_wdata,
    output logic                   a_rsp_valid,
    output logic [DATA_WIDTH-1:0]  a_rsp_rdata,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic                   b_we,
    input  logic [ADDR_BITS-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]  b_wdata,
    output logic                   b_rsp_valid,
    output logic [DATA_WIDTH-1:0]  b_rsp_rdata,
    output logic                   mem_WriteEnable,
    output logic [ADDR_BITS/2-1:0] mem_X_addr,
    output logic [ADDR_BITS/2-1:0] mem_Y_addr,
    output logic [DATA_WIDTH-1:0]  mem_Data_in,
    input  logic [DATA_WIDTH-1:0]  mem_Data_out,
    output logic                   busy
);
    localparam int HALF = ADDR_BITS / 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

    state_t                 r_state, w_next;
    logic                   r_last_b;   // 1: B was granted last
    logic                   r_owner_b;  // 1: B owns the in-flight transaction
    logic                   r_we;
    logic                   r_mem_we;
    logic [HALF-1:0]        r_x, r_y;
    logic [DATA_WIDTH-1:0]  r_din;
    logic                   r_a_rsp_valid, r_b_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_a_rdata, r_b_rdata;

    logic                   w_grant_a, w_grant_b;
    logic                   w_sel_we;
    logic [ADDR_BITS-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [DATA_WIDTH-1:0]  w_rsp_data;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Grant logic: on contention, the requester that was not granted last wins.
    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_a = a_valid && (!b_valid || r_last_b);
                w_grant_b = b_valid && (!a_valid || !r_last_b);
                if (w_grant_a || w_grant_b) w_next = S_ISSUE;
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
    // Writes return zero so a stale read value never looks like a response.
    assign w_rsp_data  = r_we ? '0 : mem_Data_out;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_last_b      <= 1'b1;
            r_owner_b     <= 1'b0;
            r_we          <= 1'b0;
            r_mem_we      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_din         <= '0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
        end else begin
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_owner_b <= w_grant_b;
                        r_last_b  <= w_grant_b;
                        r_we      <= w_sel_we;
                        r_x       <= w_sel_addr[ADDR_BITS-1:HALF];
                        r_y       <= w_sel_addr[HALF-1:0];
                        r_din     <= w_sel_wdata;
                        // Memory write strobe is high only for the ISSUE cycle.
                        r_mem_we  <= w_sel_we;
                    end
                end
                S_ISSUE: r_mem_we <= 1'b0;
                S_CAPTURE: begin
                    if (r_owner_b) begin
                        r_b_rsp_valid <= 1'b1;
                        r_b_rdata     <= w_rsp_data;
                    end else begin
                        r_a_rsp_valid <= 1'b1;
                        r_a_rdata     <= w_rsp_data;
                    end
                end
                default: r_mem_we <= 1'b0;
            endcase
        end
    end

    assign a_ready         = w_grant_a;
    assign b_ready         = w_grant_b;
    assign a_rsp_valid     = r_a_rsp_valid;
    assign a_rsp_rdata     = r_a_rdata;
    assign b_rsp_valid     = r_b_rsp_valid;
    assign b_rsp_rdata     = r_b_rdata;
    assign mem_WriteEnable = r_mem_we;
    assign mem_X_addr      = r_x;
    assign mem_Y_addr      = r_y;
    assign mem_Data_in     = r_din;
    assign busy            = (r_state != S_IDLE);
endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the X/Y-addressed data memory (`datamem`).
- Requester A is the CPU load/store unit; requester B is the DMA/debug port.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.
- The block splits the flat address into X (row) and Y (column), and drives the memory's WriteEnable, X_addr, Y_addr and Data_in from registers.
- It captures the memory's registered Data_out and returns it to the winning requester.

Parameters:
- ADDR_BITS, 8, flat word address width; must be even; X = upper half, Y = lower half.
- DATA_WIDTH, 8, data word width.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A request valid.
- a_ready  output  1  requester A request accepted this cycle.
- a_we  input  1  requester A: 1 = write, 0 = read.
- a_addr  input  ADDR_BITS  requester A flat address.
- a_wdata  input  DATA_WIDTH  requester A write data.
- a_rsp_valid  output  1  requester A response pulse.
- a_rsp_rdata  output  DATA_WIDTH  requester A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_rdata: same as A, for requester B.
- mem_WriteEnable  output  1  to datamem WriteEnable.
- mem_X_addr  output  ADDR_BITS/2  to datamem X_addr.
- mem_Y_addr  output  ADDR_BITS/2  to datamem Y_addr.
- mem_Data_in  output  DATA_WIDTH  to datamem Data_in.
- mem_Data_out  input  DATA_WIDTH  from datamem Data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, CAPTURE. All state, latched request fields, the last_grant register and response outputs are registers on Clock/Resetn.
- Reset (Resetn low, asynchronous):
  - state = IDLE, last_grant = B, so A wins the first contention.
  - All rsp_valid = 0, all rsp_rdata = 0.
  - mem_WriteEnable = 0, mem_X_addr = mem_Y_addr = mem_Data_in = 0.
  - Any in-flight transaction is dropped with no response.
- IDLE: a_ready/b_ready are combinational grant signals, high only in IDLE, and at most one is high.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - On the grant edge: latch we, addr and wdata; record the owner; update last_grant; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (1 cycle):
  - mem_X_addr = latched addr[ADDR_BITS-1:ADDR_BITS/2]; mem_Y_addr = latched addr[ADDR_BITS/2-1:0]; mem_Data_in = latched wdata; mem_WriteEnable = latched we.
  - The memory performs the access on the edge that ends ISSUE; next state is CAPTURE.
- CAPTURE (1 cycle):
  - mem_WriteEnable = 0; address held.
  - On the ending edge: owner's rsp_rdata <= mem_Data_out for a read, or 0 for a write. Owner's rsp_valid <= 1 for exactly one cycle. Next state is IDLE.
- mem_WriteEnable is a registered decode of state, so it is high only in ISSUE and never glitches.
- Latency and throughput:
  - Acceptance at edge E0: memory access at E0+1, rsp_valid high during E0+2..E0+3.
  - A new grant is possible in the same cycle rsp_valid is high (IDLE), so peak throughput is 1 transaction per 3 cycles.
- Handshake rules:
  - A requester holds valid, we, addr and wdata stable until ready.
  - Deasserting valid before ready withdraws the request, which is legal.
  - ready never asserts without valid.
- The non-owner's rsp_valid stays 0. rsp_rdata holds its last value between pulses.
- Read of a never-written location returns whatever datamem returns (X in simulation). This is passed through unchanged.
- Reset asserted during ISSUE: mem_WriteEnable drops immediately; the write may or may not land (memory is unreset). The bench must not check that location.

Test Plan:
- Reset, A writes addr 0x3C data 0xA5 → a_ready pulse in IDLE; mem_X_addr=3, mem_Y_addr=0xC, mem_WriteEnable high exactly 1 cycle; a_rsp_valid one pulse 2 cycles after acceptance, a_rsp_rdata=0.
- A reads 0x3C after the previous write → a_rsp_rdata=0xA5 with a_rsp_valid 2 cycles after acceptance; b_rsp_valid stays 0.
- A and B both valid continuously with reads of 0x01 / 0x02 → grants alternate A, B, A, B; one grant every 3 cycles; each response goes to the correct requester.
- B alone valid for 3 transactions (writes 0xFF←0x11, 0x00←0x22, read 0xFF) → B granted every 3 cycles; read returns 0x11; corner addresses give X/Y = F/F and 0/0.
- A valid, then withdrawn in a cycle where state≠IDLE, before ready → no grant, no memory access, no response.
- Resetn low in the middle of the ISSUE cycle → mem_WriteEnable low and busy low asynchronously; no rsp_valid; after release, A wins the first contention.
